// File: rtl/mpeg2_stream_serializer.sv
// mpeg2_stream_serializer: buffers 256-bit MPEG2 stream words from the encoder
// in a word FIFO and emits them as eight 32-bit beats (byte 0 in bits 7:0 of
// the first beat) on a valid/ready interface. Words arriving while the FIFO is
// full are dropped and flagged on the sticky o_overflow.
// Optional feature macro: MPEG2_SERIALIZER_BYTECOUNT_EN adds o_byte_count and
// o_seq_bytes (bytes since last sequence end / size of last sequence).
module mpeg2_stream_serializer #(
    parameter int FIFO_AW = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 i_en,
    input  logic                 i_last,
    input  logic [255:0]         i_data,
    output logic                 o_valid,
    input  logic                 o_ready,
    output logic [31:0]          o_data,
    output logic                 o_last,
    output logic                 o_overflow,
`ifdef MPEG2_SERIALIZER_BYTECOUNT_EN
    output logic [31:0]          o_byte_count,
    output logic [31:0]          o_seq_bytes,
`endif
    output logic [FIFO_AW:0]     o_level
);

    localparam int DEPTH = 1 << FIFO_AW;
    localparam logic [FIFO_AW:0] FULL_LEVEL = {1'b1, {FIFO_AW{1'b0}}};

    // Entry layout: bit 256 = end-of-sequence marker, bits 255:0 = stream word.
    logic [256:0]         mem [DEPTH];
    logic [FIFO_AW-1:0]   wr_ptr;
    logic [FIFO_AW-1:0]   rd_ptr;
    logic [FIFO_AW:0]     level;
    logic                 overflow;

    logic [256:0]         word;
    logic [2:0]           lane;
    logic                 loaded;

    logic                 push;
    logic                 pop;
    logic                 beat_done;
    logic                 fifo_empty;

    // Full is judged on the registered level, so a same-cycle pop never frees
    // room for the incoming word.
    always_comb begin
        fifo_empty = (level == '0);
        beat_done  = loaded & o_ready;
        push       = i_en & (level != FULL_LEVEL);
        pop        = ~fifo_empty & (~loaded | (beat_done & (lane == 3'd7)));
    end

    // Word storage; contents are don't-care until written, so no reset needed.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= {i_last, i_data};
        end
    end

    // FIFO pointers, occupancy and the sticky drop flag.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            level    <= '0;
            overflow <= 1'b0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({push, pop})
                2'b10:   level <= level + 1'b1;
                2'b01:   level <= level - 1'b1;
                default: level <= level;
            endcase
            if (i_en && !push) overflow <= 1'b1;
        end
    end

    // Serializer holding register: steps through lanes, reloads on the last
    // beat's handshake so consecutive words stream without a bubble.
    always_ff @(posedge clk) begin
        if (rst) begin
            word   <= '0;
            lane   <= '0;
            loaded <= 1'b0;
        end else if (pop) begin
            word   <= mem[rd_ptr];
            lane   <= '0;
            loaded <= 1'b1;
        end else if (beat_done) begin
            lane <= lane + 1'b1;
            if (lane == 3'd7) loaded <= 1'b0;
        end
    end

`ifdef MPEG2_SERIALIZER_BYTECOUNT_EN
    logic [31:0] byte_count;
    logic [31:0] seq_bytes;

    // Byte accounting per completed beat; a sequence end snapshots the total.
    always_ff @(posedge clk) begin
        if (rst) begin
            byte_count <= '0;
            seq_bytes  <= '0;
        end else if (beat_done) begin
            if (o_last) begin
                seq_bytes  <= byte_count + 32'd4;
                byte_count <= '0;
            end else begin
                byte_count <= byte_count + 32'd4;
            end
        end
    end

    assign o_byte_count = byte_count;
    assign o_seq_bytes  = seq_bytes;
`endif

    // Output view of the holding register.
    always_comb begin
        o_valid    = loaded;
        o_data     = word[lane*32 +: 32];
        o_last     = loaded & word[256] & (lane == 3'd7);
        o_overflow = overflow;
        o_level    = level;
    end

endmodule

// File: tb/tb_mpeg2_stream_serializer.sv
// Directed bench for mpeg2_stream_serializer: a beat-level reference queue is
// filled as words are pushed and drained by a handshake monitor.
module tb_mpeg2_stream_serializer;

    logic         clk;
    logic         rst;
    logic         i_en;
    logic         i_last;
    logic [255:0] i_data;
    logic         o_valid;
    logic         o_ready;
    logic [31:0]  o_data;
    logic         o_last;
    logic         o_overflow;
    logic [4:0]   o_level;
`ifdef MPEG2_SERIALIZER_BYTECOUNT_EN
    logic [31:0]  o_byte_count;
    logic [31:0]  o_seq_bytes;
`endif

    mpeg2_stream_serializer #(.FIFO_AW(4)) dut (
        .clk        (clk),
        .rst        (rst),
        .i_en       (i_en),
        .i_last     (i_last),
        .i_data     (i_data),
        .o_valid    (o_valid),
        .o_ready    (o_ready),
        .o_data     (o_data),
        .o_last     (o_last),
        .o_overflow (o_overflow),
`ifdef MPEG2_SERIALIZER_BYTECOUNT_EN
        .o_byte_count (o_byte_count),
        .o_seq_bytes  (o_seq_bytes),
`endif
        .o_level    (o_level)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    // expected beats: {last, data}
    logic [32:0] exp_q [$];

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] want);
        n_cmp++;
        if (got !== want) begin
            n_bad++;
            $display("FAIL %s: observed 0x%0h expected 0x%0h at %0t", tag, got, want, $time);
        end
    endtask

    function automatic logic [255:0] mk_word(input logic [7:0] base);
        logic [255:0] w;
        for (int k = 0; k < 32; k++) w[k*8 +: 8] = base + 8'(k);
        return w;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // drive one word this cycle; keep=0 marks a word the DUT must drop
    task automatic send(input logic [7:0] base, input logic last, input logic keep);
        logic [255:0] w;
        w      = mk_word(base);
        i_en   = 1'b1;
        i_data = w;
        i_last = last;
        if (keep) begin
            for (int l = 0; l < 8; l++)
                exp_q.push_back({(last && l == 7), w[l*32 +: 32]});
        end
        tick();
    endtask

    task automatic idle();
        i_en   = 1'b0;
        i_last = 1'b0;
    endtask

    task automatic wait_drain(input int budget);
        int n;
        n = 0;
        while ((exp_q.size() != 0 || o_valid) && n < budget) begin
            tick();
            n++;
        end
        if (n >= budget) chk("drain_timeout", 64'(exp_q.size()), 64'd0);
    endtask

    // handshake monitor and stall-stability check, sampled at the falling edge
    logic        prev_stall = 1'b0;
    logic [31:0] prev_data  = '0;
    logic [32:0] e;
    always @(negedge clk) begin
        if (rst) begin
            prev_stall = 1'b0;
        end else begin
            if (prev_stall) begin
                chk("stall_valid", 64'(o_valid), 64'd1);
                chk("stall_data", 64'(o_data), 64'(prev_data));
            end
            if (o_valid && o_ready) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_beat", 64'(o_data), 64'd0);
                    chk("unexpected_beat_valid", 64'(o_valid), 64'd0);
                end else begin
                    e = exp_q.pop_front();
                    chk("beat_data", 64'(o_data), 64'(e[31:0]));
                    chk("beat_last", 64'(o_last), 64'(e[32]));
                end
            end
            prev_stall = o_valid && !o_ready;
            prev_data  = o_data;
        end
    end

    logic [7:0] base;
    int         sent;

    initial begin
        rst     = 1'b1;
        i_en    = 1'b0;
        i_last  = 1'b0;
        i_data  = '0;
        o_ready = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        @(negedge clk);
        chk("rst_valid", 64'(o_valid), 64'd0);
        chk("rst_last", 64'(o_last), 64'd0);
        chk("rst_data", 64'(o_data), 64'd0);
        chk("rst_overflow", 64'(o_overflow), 64'd0);
        chk("rst_level", 64'(o_level), 64'd0);
`ifdef MPEG2_SERIALIZER_BYTECOUNT_EN
        chk("rst_byte_count", 64'(o_byte_count), 64'd0);
        chk("rst_seq_bytes", 64'(o_seq_bytes), 64'd0);
`endif
        tick();

        // single word, latency N+2
        i_en   = 1'b1;
        i_data = mk_word(8'h00);
        i_last = 1'b0;
        for (int l = 0; l < 8; l++) exp_q.push_back({1'b0, i_data[l*32 +: 32]});
        @(negedge clk);
        chk("lat_cycN_valid", 64'(o_valid), 64'd0);
        tick();
        idle();
        @(negedge clk);
        chk("lat_cycN1_valid", 64'(o_valid), 64'd0);
        chk("lat_cycN1_level", 64'(o_level), 64'd1);
        tick();
        @(negedge clk);
        chk("lat_cycN2_valid", 64'(o_valid), 64'd1);
        chk("lat_first_beat", 64'(o_data), 64'h03020100);
        wait_drain(50);

        // three back-to-back words, last on third, no gaps
        tick();
        send(8'h20, 1'b0, 1'b1);
        send(8'h40, 1'b0, 1'b1);
        send(8'h60, 1'b1, 1'b1);
        idle();
        for (int i = 0; i < 23; i++) begin
            @(negedge clk);
            chk("stream_no_gap", 64'(o_valid), 64'd1);
            tick();
        end
        @(negedge clk);
        chk("stream_end_valid", 64'(o_valid), 64'd0);
        chk("stream_queue_empty", 64'(exp_q.size()), 64'd0);
`ifdef MPEG2_SERIALIZER_BYTECOUNT_EN
        chk("seq_bytes", 64'(o_seq_bytes), 64'd96);
        chk("byte_count_cleared", 64'(o_byte_count), 64'd0);
`endif
        tick();

        // overflow: ready low, 18 words; first loads the serializer, 16 fill
        // the FIFO, the 18th is dropped
        o_ready = 1'b0;
        for (int i = 0; i < 18; i++) send(8'(8'h80 + 8'(i)), 1'b0, (i != 17));
        idle();
        @(negedge clk);
        chk("ovf_level", 64'(o_level), 64'd16);
        chk("ovf_flag", 64'(o_overflow), 64'd1);
        chk("ovf_valid_held", 64'(o_valid), 64'd1);
        tick();
        o_ready = 1'b1;
        wait_drain(400);
        chk("ovf_flag_sticky", 64'(o_overflow), 64'd1);
        chk("ovf_level_empty", 64'(o_level), 64'd0);

        // simultaneous push and pop at level 8
        o_ready = 1'b0;
        for (int i = 0; i < 9; i++) send(8'(8'hA0 + 8'(i)), 1'b0, 1'b1);
        idle();
        @(negedge clk);
        chk("lvl8_before", 64'(o_level), 64'd8);
        tick();
        o_ready = 1'b1;
        repeat (7) tick();
        send(8'hB0, 1'b1, 1'b1);
        idle();
        @(negedge clk);
        chk("lvl8_push_pop", 64'(o_level), 64'd8);
        wait_drain(400);

        // random ready, 40 words paced on level
        sent = 0;
        while (sent < 40) begin
            o_ready = 1'($urandom_range(0, 1));
            if (o_level < 5'd12) begin
                base = 8'(sent * 7 + 3);
                send(base, (sent % 10 == 9), 1'b1);
                sent++;
            end else begin
                idle();
                tick();
            end
        end
        idle();
        for (int i = 0; i < 2000 && exp_q.size() != 0; i++) begin
            o_ready = 1'($urandom_range(0, 1));
            tick();
        end
        o_ready = 1'b1;
        wait_drain(50);
        chk("rand_all_drained", 64'(exp_q.size()), 64'd0);

        // reset mid-word at lane 3 with 5 words queued
        o_ready = 1'b0;
        for (int i = 0; i < 6; i++) send(8'(8'hC0 + 8'(i)), 1'b0, 1'b1);
        idle();
        o_ready = 1'b1;
        repeat (3) tick();
        @(negedge clk);
        chk("pre_rst_level", 64'(o_level), 64'd5);
        chk("pre_rst_lane3", 64'(o_data), 64'hCFCECDCC);
        chk("pre_rst_overflow", 64'(o_overflow), 64'd1);
        tick();
        rst = 1'b1;
        exp_q.delete();
        tick();
        rst = 1'b0;
        @(negedge clk);
        chk("post_rst_valid", 64'(o_valid), 64'd0);
        chk("post_rst_level", 64'(o_level), 64'd0);
        chk("post_rst_overflow", 64'(o_overflow), 64'd0);
        chk("post_rst_last", 64'(o_last), 64'd0);
        tick();
        i_en   = 1'b1;
        i_data = mk_word(8'hE0);
        i_last = 1'b0;
        for (int l = 0; l < 8; l++) exp_q.push_back({1'b0, i_data[l*32 +: 32]});
        tick();
        idle();
        @(negedge clk);
        chk("fresh_cycN1_valid", 64'(o_valid), 64'd0);
        tick();
        @(negedge clk);
        chk("fresh_cycN2_valid", 64'(o_valid), 64'd1);
        chk("fresh_lane0", 64'(o_data), 64'hE3E2E1E0);
        wait_drain(50);
        tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    // absolute time guard
    initial begin
        #2000000;
        $display("FAIL global_timeout: observed running expected finished");
        $fatal(1, "timeout");
    end

endmodule
